// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multicycle MIPS stage sequencer with imem/dmem handshakes
// Chooses the per-instruction stage path from the fetched opcode; supports halt/park and counters.
module stage_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               halt,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               fetch_enable,
  output logic               decode_enable,
  output logic               execute_enable,
  output logic               memory_enable,
  output logic               writeback_enable,
  output logic               m_or_e,
  output logic               busy,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BR, C_LINK} class_t;

  localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t state, state_next;
  class_t cls, cls_next;
  logic   retire;
  logic   unused_bits;

  assign unused_bits = ^instruction[25:0];

  function automatic class_t classify(input logic [5:0] op);
    case (op)
      6'h23:               return C_LOAD;
      6'h2B:               return C_STORE;
      6'h04, 6'h05, 6'h02: return C_BR;
      6'h03:               return C_LINK;
      default:             return C_ALU;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IF;
      cls           <= C_ALU;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state <= state_next;
      cls   <= cls_next;
      if (state != S_HALT) cycle_count <= cycle_count + ONE;
      if (retire) instret_count <= instret_count + ONE;
    end
  end

  always_comb begin
    state_next       = state;
    cls_next         = cls;
    retire           = 1'b0;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    fetch_enable     = 1'b0;
    decode_enable    = 1'b0;
    execute_enable   = 1'b0;
    memory_enable    = 1'b0;
    writeback_enable = 1'b0;
    m_or_e           = 1'b0;
    busy             = (state != S_HALT);
    case (state)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fetch_enable = 1'b1;
          cls_next     = classify(instruction[31:26]);
          state_next   = S_ID;
        end
      end
      S_ID: begin
        decode_enable = 1'b1;
        state_next    = S_EX;
      end
      S_EX: begin
        execute_enable = 1'b1;
        case (cls)
          C_LOAD, C_STORE: state_next = S_MEM;
          C_BR:            retire     = 1'b1;
          default:         state_next = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          memory_enable = 1'b1;
          if (cls == C_LOAD) state_next = S_WB;
          else               retire     = 1'b1;
        end
      end
      S_WB: begin
        writeback_enable = 1'b1;
        m_or_e           = (cls == C_LOAD);
        retire           = 1'b1;
      end
      S_HALT: begin
        if (!halt) state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase
    // Halt is honoured only at the retire point, so an instruction is never aborted.
    if (retire) state_next = halt ? S_HALT : S_IF;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed bench for stage_sequencer
// Runs a 32-bit and a 4-bit counter instance side by side on shared stimulus.
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_ready, dmem_ready, halt;
  logic [31:0] instruction;

  logic        imem_req, dmem_req, fetch_enable, decode_enable, execute_enable;
  logic        memory_enable, writeback_enable, m_or_e, busy;
  logic [31:0] cycle_count, instret_count;

  logic        imem_req_w, dmem_req_w, fetch_enable_w, decode_enable_w, execute_enable_w;
  logic        memory_enable_w, writeback_enable_w, m_or_e_w, busy_w;
  logic [3:0]  cycle_count_w, instret_count_w;

  localparam logic [31:0] ADD = 32'h00221820;
  localparam logic [31:0] LW  = 32'h8C220004;
  localparam logic [31:0] SW  = 32'hAC220004;
  localparam logic [31:0] BEQ = 32'h10220002;

  // {imem_req, decode_enable, execute_enable, dmem_req, writeback_enable, busy}
  localparam logic [5:0] V_IF   = 6'b100001;
  localparam logic [5:0] V_ID   = 6'b010001;
  localparam logic [5:0] V_EX   = 6'b001001;
  localparam logic [5:0] V_MEM  = 6'b000101;
  localparam logic [5:0] V_WB   = 6'b000011;
  localparam logic [5:0] V_HALT = 6'b000000;

  int checks = 0;
  int errors = 0;
  int n_dreq, n_men, n_wb, n_fe, n_if;

  stage_sequencer #(.COUNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt(halt),
    .imem_req(imem_req), .dmem_req(dmem_req), .fetch_enable(fetch_enable),
    .decode_enable(decode_enable), .execute_enable(execute_enable),
    .memory_enable(memory_enable), .writeback_enable(writeback_enable),
    .m_or_e(m_or_e), .busy(busy), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  stage_sequencer #(.COUNT_W(4)) u_dut_w (
    .clk(clk), .reset(reset), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt(halt),
    .imem_req(imem_req_w), .dmem_req(dmem_req_w), .fetch_enable(fetch_enable_w),
    .decode_enable(decode_enable_w), .execute_enable(execute_enable_w),
    .memory_enable(memory_enable_w), .writeback_enable(writeback_enable_w),
    .m_or_e(m_or_e_w), .busy(busy_w), .cycle_count(cycle_count_w), .instret_count(instret_count_w)
  );

  function automatic logic [5:0] vec();
    return {imem_req, decode_enable, execute_enable, dmem_req, writeback_enable, busy};
  endfunction

  function automatic logic [5:0] vec_w();
    return {imem_req_w, decode_enable_w, execute_enable_w, dmem_req_w, writeback_enable_w, busy_w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; halt = 1'b0; instruction = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state",   {26'b0, vec()}, {26'b0, V_IF});
    chk("reset_fetch",   {31'b0, fetch_enable}, 32'd0);
    chk("reset_m_or_e",  {31'b0, m_or_e}, 32'd0);
    chk("reset_cycle",   cycle_count, 32'd0);
    chk("reset_instret", instret_count, 32'd0);

    // add, zero-wait fetch
    @(negedge clk); reset = 1'b1; imem_ready = 1'b1; instruction = ADD; #1;
    chk("add_if",    {26'b0, vec()}, {26'b0, V_IF});
    chk("add_fetch", {31'b0, fetch_enable}, 32'd1);
    @(negedge clk); #1; chk("add_id", {26'b0, vec()}, {26'b0, V_ID});
    @(negedge clk); #1; chk("add_ex", {26'b0, vec()}, {26'b0, V_EX});
    @(negedge clk); #1;
    chk("add_wb",      {26'b0, vec()}, {26'b0, V_WB});
    chk("add_wb_moe",  {31'b0, m_or_e}, 32'd0);
    chk("add_wb_iret", instret_count, 32'd0);
    @(negedge clk); #1;
    chk("add_ret",       {26'b0, vec()}, {26'b0, V_IF});
    chk("add_instret",   instret_count, 32'd1);
    chk("add_cycle",     cycle_count, 32'd4);

    // lw with three dmem wait cycles; a halt pulse off the retire cycle is ignored
    instruction = LW; dmem_ready = 1'b0; n_dreq = 0; n_men = 0;
    @(negedge clk); halt = 1'b1; #1; chk("lw_id", {26'b0, vec()}, {26'b0, V_ID});
    @(negedge clk); halt = 1'b0; #1; chk("lw_ex", {26'b0, vec()}, {26'b0, V_EX});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_ready = (i == 3); #1;
      n_dreq += int'(dmem_req);
      n_men  += int'(memory_enable);
    end
    chk("lw_dreq_cycles", n_dreq, 32'd4);
    chk("lw_men_pulses",  n_men, 32'd1);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk("lw_wb",     {26'b0, vec()}, {26'b0, V_WB});
    chk("lw_wb_moe", {31'b0, m_or_e}, 32'd1);
    @(negedge clk); #1;
    chk("lw_ret",     {26'b0, vec()}, {26'b0, V_IF});
    chk("lw_instret", instret_count, 32'd2);
    chk("lw_cycle",   cycle_count, 32'd12);

    // sw then beq from a fresh reset
    do_reset();
    instruction = SW; dmem_ready = 1'b1; n_wb = 0; n_men = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) instruction = BEQ;
      #1;
      n_wb  += int'(writeback_enable);
      n_men += int'(memory_enable);
      @(negedge clk);
    end
    #1;
    chk("swbeq_state",   {26'b0, vec()}, {26'b0, V_IF});
    chk("swbeq_no_wb",   n_wb, 32'd0);
    chk("swbeq_men",     n_men, 32'd1);
    chk("swbeq_instret", instret_count, 32'd2);
    chk("swbeq_cycle",   cycle_count, 32'd7);

    // five-cycle imem stall, then add with halt held over its WB cycle
    imem_ready = 1'b0; n_fe = 0; n_if = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_fe += int'(fetch_enable);
      n_if += int'(vec() == V_IF);
      @(negedge clk);
    end
    imem_ready = 1'b1; instruction = ADD; #1;
    chk("stall_no_fetch", n_fe, 32'd0);
    chk("stall_in_if",    n_if, 32'd5);
    chk("stall_fetch",    {31'b0, fetch_enable}, 32'd1);
    chk("stall_cycle",    cycle_count, 32'd12);
    @(negedge clk); #1; chk("halt_id", {26'b0, vec()}, {26'b0, V_ID});
    @(negedge clk); #1; chk("halt_ex", {26'b0, vec()}, {26'b0, V_EX});
    @(negedge clk); halt = 1'b1; #1; chk("halt_wb", {26'b0, vec()}, {26'b0, V_WB});
    @(negedge clk); #1;
    chk("halt_state",   {26'b0, vec()}, {26'b0, V_HALT});
    chk("halt_instret", instret_count, 32'd3);
    chk("halt_cycle",   cycle_count, 32'd16);
    repeat (2) @(negedge clk);
    #1;
    chk("halt_frozen", cycle_count, 32'd16);
    @(negedge clk); halt = 1'b0; #1;
    chk("halt_release_same", {26'b0, vec()}, {26'b0, V_HALT});
    @(negedge clk); #1;
    chk("halt_release_if",    {26'b0, vec()}, {26'b0, V_IF});
    chk("halt_release_cycle", cycle_count, 32'd16);

    // 17 branches: 4-bit counters wrap
    do_reset();
    instruction = BEQ; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (51) @(negedge clk);
    #1;
    chk("wrap_instret32", instret_count, 32'd17);
    chk("wrap_cycle32",   cycle_count, 32'd51);
    chk("wrap_instret4",  {28'b0, instret_count_w}, 32'd1);
    chk("wrap_cycle4",    {28'b0, cycle_count_w}, 32'd3);
    chk("wrap_state4",    {26'b0, vec_w()}, {26'b0, V_IF});

    // reset while waiting in S_MEM
    instruction = LW; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_mem_state", {26'b0, vec_w()}, {26'b0, V_MEM});
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_mem_if",       {26'b0, vec()}, {26'b0, V_IF});
    chk("rst_mem_if4",      {26'b0, vec_w()}, {26'b0, V_IF});
    chk("rst_mem_cycle4",   {28'b0, cycle_count_w}, 32'd0);
    chk("rst_mem_instret4", {28'b0, instret_count_w}, 32'd0);
    chk("rst_mem_instret",  instret_count, 32'd0);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
